// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit paths
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_DIV = 868;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with registered pointers; write while full is allowed when a pop happens in the same cycle
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = wp == rp;
  assign full = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      mem <= '{default: '0};
    end else begin
      if (do_wr) mem[wp[AW-1:0]] <= wr_data;
      wp <= wp + {{AW{1'b0}}, do_wr};
      rp <= rp + {{AW{1'b0}}, do_rd};
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, stop-bit check and a receive FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      err_clr
);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  localparam logic [2:0] LAST = 3'(UART_DATA_BITS - 1);
  uart_rx_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n;
  logic s1, s2, prev, armed, fall, zero, good, ferr, full, empty, pop, push;
  logic [1:0] live;
  // the line only arms once a real synchronized high has been seen after reset
  assign fall = armed & prev & ~s2;
  assign zero = cnt == 16'd0;
  assign dout_valid = ~empty;
  assign pop = dout_valid & dout_ready;
  assign push = good & (~full | pop);
  always_comb begin
    state_n = state;
    cnt_n = zero ? cnt : cnt - 16'd1;
    idx_n = idx;
    sh_n = sh;
    good = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_n = START;
        cnt_n = HALF;
      end
      START: if (zero) begin
        state_n = s2 ? IDLE : DATA;
        cnt_n = FULL;
        idx_n = 3'd0;
      end
      DATA: if (zero) begin
        sh_n = {s2, sh[UART_DATA_BITS-1:1]};
        cnt_n = FULL;
        idx_n = idx + 3'd1;
        state_n = idx == LAST ? STOP : DATA;
      end
      STOP: if (zero) begin
        state_n = IDLE;
        good = s2;
        ferr = ~s2;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      live <= 2'b00;
      armed <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      prev <= s2;
      live <= {live[0], 1'b1};
      armed <= armed | (live[1] & s2);
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      frame_err <= ferr;
      overrun <= (good & full & ~pop) | (overrun & ~err_clr);
    end
  end
  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(sh_n),
    .rd_en(pop),
    .rd_data(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx with a frame-level reference model
module tb_uart_rx;
  localparam int DIV = 16, DIVB = 868, DEPTH = 4;
  logic clk = 0, rst = 1, rxd = 1, rxd_b = 1, dout_ready = 1, err_clr = 0;
  logic [7:0] dout, dout_b;
  logic dout_valid, dout_valid_b, frame_err, frame_err_b, overrun, overrun_b;
  int tests = 0, fails = 0, cyc = 0, ferr_cnt = 0, ferr_cyc = 0, exp_ferr = 0, rx_cnt = 0, t0 = 0;
  bit exp_ovr = 0;
  logic [7:0] exp_a[$], exp_b[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr));
  uart_rx #(.CLK_DIV(DIVB), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .dout_ready(1'b1), .frame_err(frame_err_b), .overrun(overrun_b), .err_clr(1'b0));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // reference model: a good frame is queued unless the consumer is stalled and DEPTH bytes are pending
  task automatic send_a(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr++;
    else if (!dout_ready && exp_a.size() >= DEPTH) exp_ovr = 1;
    else exp_a.push_back(b);
    rxd = 0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) tick();
    end
    rxd = stop;
    repeat (DIV) tick();
    rxd = 1;
  endtask
  task automatic send_b(input logic [7:0] b);
    exp_b.push_back(b);
    rxd_b = 0;
    repeat (DIVB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd_b = b[i];
      repeat (DIVB) tick();
    end
    rxd_b = 1;
    repeat (DIVB) tick();
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 4 * DIV && exp_a.size() != 0; i++) tick();
    chk(name, exp_a.size(), 0);
  endtask
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      rx_cnt++;
      if (exp_a.size() == 0) chk("rx_extra", {24'h0, dout}, 32'h100);
      else chk("rx_byte", {24'h0, dout}, {24'h0, exp_a.pop_front()});
    end
    if (dout_valid_b) begin
      if (exp_b.size() == 0) chk("rx_b_extra", {24'h0, dout_b}, 32'h100);
      else chk("rx_b_byte", {24'h0, dout_b}, {24'h0, exp_b.pop_front()});
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (frame_err_b) chk("frame_err_b", 1, 0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int base;
    logic [7:0] b;
    logic s;
    repeat (3) tick();
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 0;
    repeat (2 * DIV) tick();
    base = rx_cnt;
    send_a(8'hC3, 1);
    repeat (2 * DIV) tick();
    drain("clean_drain");
    chk("clean_count", rx_cnt - base, 1);
    chk("clean_ferr", ferr_cnt, 0);
    chk("clean_ovr", overrun, 0);
    base = rx_cnt;
    rxd = 0;
    repeat (5) tick();
    rxd = 1;
    repeat (2 * DIV) tick();
    chk("glitch_count", rx_cnt - base, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    send_a(8'h3C, 1);
    repeat (2 * DIV) tick();
    drain("glitch_next");
    t0 = cyc;
    send_a(8'h55, 0);
    repeat (2 * DIV) tick();
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_timing", (ferr_cyc - t0 >= 153) && (ferr_cyc - t0 <= 155), 1);
    chk("ferr_valid", dout_valid, 0);
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 4) != 0;
      send_a(b, s);
      repeat ($urandom_range(1, 2 * DIV)) tick();
    end
    repeat (2 * DIV) tick();
    drain("rand_drain");
    chk("rand_ferr", ferr_cnt, exp_ferr);
    send_a(8'hA5, 1);
    send_a(8'h5A, 1);
    repeat (2 * DIV) tick();
    drain("b2b_drain");
    dout_ready = 0;
    for (int n = 1; n <= 5; n++) begin
      send_a(8'(n), 1);
      repeat (DIV) tick();
    end
    repeat (DIV) tick();
    chk("ovr_set", overrun, exp_ovr);
    chk("ovr_valid", dout_valid, 1);
    dout_ready = 1;
    drain("ovr_pops");
    tick();
    chk("ovr_empty", dout_valid, 0);
    chk("ovr_sticky", overrun, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    exp_ovr = 0;
    chk("ovr_clr", overrun, exp_ovr);
    dout_ready = 0;
    send_a(8'h11, 1);
    repeat (DIV) tick();
    send_a(8'h22, 1);
    repeat (DIV) tick();
    chk("rst_queued", dout_valid, 1);
    rxd = 0;
    repeat (DIV) tick();
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      repeat (DIV) tick();
    end
    rxd = 1;
    repeat (DIV / 2) tick();
    rst = 1;
    #1;
    exp_a.delete();
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    repeat (2) tick();
    rst = 0;
    dout_ready = 1;
    repeat (20 * DIV) tick();
    send_a(8'h7E, 1);
    repeat (2 * DIV) tick();
    drain("post_rst");
    send_b(8'h00);
    send_b(8'hFF);
    for (int i = 0; i < 2 * DIVB && exp_b.size() != 0; i++) tick();
    chk("b_drain", exp_b.size(), 0);
    chk("final_ferr", ferr_cnt, exp_ferr);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
